// File: rtl/pwm_capture_multi_channel_pkg.sv
// Shared constants and helpers for the 16-channel PWM duty decoder.
// The channel count and slice indexing match the PWM generator's packed compare layout.
package pwm_capture_multi_channel_pkg;

    localparam int unsigned CHANNELS = 16;

    // Returns the LSB position of channel ch within a packed bus of width-bit words.
    function automatic int unsigned slice_lo(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/pwm_capture_channel.sv
// One capture channel: input synchroniser, per-frame high-cycle accumulator, and a
// duty/overflow latch that saturates an always-high frame to all ones.
module pwm_capture_channel
    import pwm_capture_multi_channel_pkg::*;
#(
    parameter int unsigned BIT_LENGTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  pwm_i,
    input  logic                  frame_end_i,
    output logic [BIT_LENGTH-1:0] duty_o,
    output logic                  overflow_o
);

    localparam logic [BIT_LENGTH:0] FullFrame = {1'b1, {BIT_LENGTH{1'b0}}};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [BIT_LENGTH:0]    acc_q, acc_d;
    logic [BIT_LENGTH:0]    total;
    logic [BIT_LENGTH-1:0]  duty_q, duty_d;
    logic                   ovf_q, ovf_d;
    logic                   s;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pwm_i};
        s      = sync_q[SYNC_STAGES-1];
        total  = acc_q + {{BIT_LENGTH{1'b0}}, s};
        acc_d  = total;
        duty_d = duty_q;
        ovf_d  = ovf_q;
        if (frame_end_i) begin
            acc_d = '0;
            // A count of exactly 2^BIT_LENGTH does not fit the duty word.
            if (total == FullFrame) begin
                duty_d = '1;
                ovf_d  = 1'b1;
            end else begin
                duty_d = total[BIT_LENGTH-1:0];
                ovf_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
            acc_q  <= '0;
            duty_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            acc_q  <= acc_d;
            duty_q <= duty_d;
            ovf_q  <= ovf_d;
        end
    end

    assign duty_o     = duty_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/pwm_capture_multi_channel.sv
// 16-channel PWM duty decoder: a shared free-running frame counter drives all channels,
// and Valid pulses on the cycle the latched duty words become visible.
module pwm_capture_multi_channel
    import pwm_capture_multi_channel_pkg::*;
#(
    parameter int unsigned BIT_LENGTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [CHANNELS-1:0]            PWMs,
    output logic [BIT_LENGTH*CHANNELS-1:0] Duties,
    output logic [CHANNELS-1:0]            Overflow,
    output logic                           Valid
);

    logic [BIT_LENGTH-1:0] frame_count_q, frame_count_d;
    logic                  valid_q, valid_d;
    logic                  frame_end;

    always_comb begin
        frame_end     = (frame_count_q == {BIT_LENGTH{1'b1}});
        frame_count_d = frame_count_q + {{(BIT_LENGTH-1){1'b0}}, 1'b1};
        valid_d       = frame_end;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_count_q <= '0;
            valid_q       <= 1'b0;
        end else begin
            frame_count_q <= frame_count_d;
            valid_q       <= valid_d;
        end
    end

    assign Valid = valid_q;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        pwm_capture_channel #(
            .BIT_LENGTH (BIT_LENGTH),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_channel (
            .CLK        (CLK),
            .RST        (RST),
            .pwm_i      (PWMs[ch]),
            .frame_end_i(frame_end),
            .duty_o     (Duties[slice_lo(ch, BIT_LENGTH) +: BIT_LENGTH]),
            .overflow_o (Overflow[ch])
        );
    end

endmodule

// File: tb/tb_pwm_capture_multi_channel.sv
// Scoreboard bench: the stimulus side models each frame as a plain count of delayed input
// bits and queues the expected result; a negedge monitor pops and checks on every Valid.
module tb_pwm_capture_multi_channel;

    localparam int BL    = 8;
    localparam int SS    = 2;
    localparam int NCH   = 16;
    localparam int FRAME = 256;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic [NCH-1:0]     PWMs = '0;
    logic [BL*NCH-1:0]  Duties;
    logic [NCH-1:0]     Overflow;
    logic               Valid;

    pwm_capture_multi_channel #(
        .BIT_LENGTH (BL),
        .SYNC_STAGES(SS)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .PWMs    (PWMs),
        .Duties  (Duties),
        .Overflow(Overflow),
        .Valid   (Valid)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int                stamp;
        logic [BL*NCH-1:0] duties;
        logic [NCH-1:0]    ovf;
    } exp_t;

    exp_t           exp_q[$];
    int             tests = 0;
    int             fails = 0;
    int             tb_cyc = 0;
    logic           rst_smp = 1'b0;

    // Reference model state: inputs seen since reset release, counts in the current frame.
    logic [NCH-1:0] in_hist[$];
    int             k = 0;
    int             pos = 0;
    int             ones[NCH];
    int             cmp[NCH];
    int             phase[NCH];
    int             t = 0;

    always @(posedge CLK) begin
        tb_cyc  <= tb_cyc + 1;
        rst_smp <= RST;
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            if (fails <= 20) $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Drive one cycle's inputs and advance the model to the posedge that will sample them.
    task automatic step(input logic [NCH-1:0] vec, input logic rst);
        @(posedge CLK);
        #1;
        PWMs = vec;
        RST  = rst;
        if (rst) begin
            in_hist.delete();
            k   = 0;
            pos = 0;
            for (int n = 0; n < NCH; n++) ones[n] = 0;
        end else begin
            in_hist.push_back(vec);
            k++;
            if (k > SS) begin
                logic [NCH-1:0] d;
                d = in_hist[k-1-SS];
                for (int n = 0; n < NCH; n++) ones[n] += int'(d[n]);
            end
            pos++;
            if (pos == FRAME) begin
                exp_t e;
                e.stamp  = tb_cyc + 1;
                e.duties = '0;
                e.ovf    = '0;
                for (int n = 0; n < NCH; n++) begin
                    if (ones[n] == FRAME) begin
                        e.duties[n*BL +: BL] = 8'hFF;
                        e.ovf[n]             = 1'b1;
                    end else begin
                        e.duties[n*BL +: BL] = ones[n][BL-1:0];
                    end
                    ones[n] = 0;
                end
                exp_q.push_back(e);
                pos = 0;
            end
        end
    endtask

    function automatic logic [NCH-1:0] gen_vec(input int tt, input int mode);
        logic [NCH-1:0] v;
        v = '0;
        for (int n = 0; n < NCH; n++) begin
            case (mode)
                0:       v[n] = 1'b0;
                1:       v[n] = 1'b1;
                3:       v[n] = 1'($urandom_range(0, 1));
                default: v[n] = (((tt + phase[n]) % FRAME) < cmp[n]);
            endcase
        end
        if (mode == 4) v[3] = tt[0];
        return v;
    endfunction

    task automatic run(input int cycles, input int mode);
        repeat (cycles) begin
            step(gen_vec(t, mode), 1'b0);
            t++;
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) step('0, 1'b1);
        @(posedge CLK);
        #1;
        check("reset_state", {15'd0, Duties, Overflow, Valid}, '0);
    endtask

    task automatic reset_at(input int fc, input int mode);
        int guard;
        guard = 0;
        while (pos != fc && guard < 2 * FRAME) begin
            step(gen_vec(t, mode), 1'b0);
            t++;
            guard++;
        end
        check("reset_point_reached", pos, fc);
        step(gen_vec(t, mode), 1'b1);
        t++;
    endtask

    task automatic random_cmps();
        for (int n = 0; n < NCH; n++) begin
            cmp[n]   = $urandom_range(0, FRAME - 1);
            phase[n] = $urandom_range(0, FRAME - 1);
        end
    endtask

    // Monitor: checks every Valid against the scoreboard and that outputs hold in between.
    logic [BL*NCH-1:0] held_d = '0;
    logic [NCH-1:0]    held_o = '0;
    logic              active = 1'b0;

    always @(negedge CLK) begin
        if (rst_smp) begin
            active = 1'b1;
            held_d = '0;
            held_o = '0;
        end
        if (active) begin
            if (Valid === 1'b1) begin
                check("valid_expected", {159'd0, exp_q.size() != 0}, 160'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("valid_cycle", tb_cyc, e.stamp);
                    check("duties", {32'd0, Duties}, {32'd0, e.duties});
                    check("overflow", {144'd0, Overflow}, {144'd0, e.ovf});
                    held_d = e.duties;
                    held_o = e.ovf;
                end
            end else begin
                check("hold", {15'd0, Duties, Overflow, Valid}, {15'd0, held_d, held_o, 1'b0});
            end
        end
    end

    initial begin
        for (int n = 0; n < NCH; n++) begin
            ones[n]  = 0;
            cmp[n]   = 0;
            phase[n] = 0;
        end

        do_reset(2);
        run(3 * FRAME, 0);

        do_reset(1);
        run(3 * FRAME, 1);

        for (int n = 0; n < NCH; n++) begin
            cmp[n]   = 16 * n + 5;
            phase[n] = $urandom_range(0, FRAME - 1);
        end
        run(3 * FRAME, 2);

        random_cmps();
        cmp[0] = 0;
        cmp[1] = 255;
        run(2 * FRAME, 2);

        reset_at(100, 1);
        run(2 * FRAME + 10, 2);
        reset_at(255, 1);
        run(2 * FRAME + 10, 2);

        random_cmps();
        run(3 * FRAME, 4);

        run(2 * FRAME, 3);

        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check("no_pending_valid", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
